hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage core.
- Generates the write-enable, flush and bubble controls for PC, IF/ID, ID/EX and EX/MEM.
- Resolves load-use hazards, taken-branch flushes and wait states from the instruction and data memory handshakes.
- Sits beside the ID stage and drives the IF_IDWrite input of the IF/ID register directly.

Parameters:
REG_AW, 5, register-address width
TIMEOUT, 255, max consecutive FETCH_WAIT cycles before fetch_err is set (1..2^CNT_W-1)
CNT_W, 8, width of the wait-cycle counter

Ports:
clk  in  1  clock, all state updates on posedge
startin  in  1  synchronous active-high reset
ID_rs  in  REG_AW  rs field of instruction in ID
ID_rt  in  REG_AW  rt field of instruction in ID
ID_uses_rt  in  1  ID instruction reads rt
EX_memread  in  1  instruction in EX is a load
EX_rt  in  REG_AW  load destination in EX
branch_taken  in  1  branch/jump resolved taken in ID this cycle
imem_ready  in  1  instruction memory returned valid data this cycle
mem_req  in  1  instruction in MEM accesses data memory
dmem_ready  in  1  data memory completed the access this cycle
PCWrite  out  1  PC update enable
IF_IDWrite  out  1  IF/ID register write enable
IF_IDFlush  out  1  load NOP (32'b0) into IF/ID
ID_EXWrite  out  1  ID/EX write enable
ID_EXBubble  out  1  zero ID/EX control fields
EX_MEMWrite  out  1  EX/MEM write enable
fetch_err  out  1  sticky fetch-timeout flag
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset: clk and startin as named above; reset is synchronous, active-high.
  - startin=1 at posedge sets state=RUN, wait counter=0, fetch_err=0.
  - While startin=1: all enables=0, IF_IDFlush=1, ID_EXBubble=1.
- Outputs are combinational from state plus current inputs; only state, counter and fetch_err are registered.
- States: RUN=0, MEM_WAIT=1, FETCH_WAIT=2. A load-use stall is single-cycle and is handled in RUN, with no state of its own.
- Hazard terms:
  - load_use = EX_memread & EX_rt!=0 & (EX_rt==ID_rs | (ID_uses_rt & EX_rt==ID_rt)).
  - mem_stall = mem_req & ~dmem_ready.
  - fetch_stall = ~imem_ready.
- Priority each cycle (highest first):
  1. mem_stall: all four enables=0, no flush/bubble; next state MEM_WAIT.
  2. branch_taken: PCWrite=1, IF_IDWrite=1, IF_IDFlush=1, ID_EXWrite=1, EX_MEMWrite=1. Flush applies even if fetch_stall (the fetched word is discarded). Next state RUN.
  3. load_use: PCWrite=0, IF_IDWrite=0, ID_EXWrite=1, ID_EXBubble=1, EX_MEMWrite=1. Next state RUN.
  4. fetch_stall: PCWrite=0, IF_IDWrite=0, ID_EXWrite=1, ID_EXBubble=1, EX_MEMWrite=1. Next state FETCH_WAIT, counter increments.
  5. Otherwise all enables=1, flush/bubble=0.
- MEM_WAIT:
  - Holds all enables=0 until dmem_ready=1.
  - On the dmem_ready cycle, evaluate priorities 2-5 as in RUN and go to the resulting state.
- FETCH_WAIT:
  - Same outputs as priority 4 while ~imem_ready.
  - Counter saturates at 2^CNT_W-1.
  - When counter reaches TIMEOUT, fetch_err is set to 1 (sticky until startin).
  - On imem_ready=1, clear the counter and return to RUN outputs for that cycle.
  - mem_stall in FETCH_WAIT takes precedence: go to MEM_WAIT; the counter is held, not cleared.
- load_use with EX_rt=0 never stalls.
- Simultaneous load_use & branch_taken: branch wins. ID gets flushed, so the stall is unnecessary.
- No output glitch requirement; outputs are sampled at posedge by the pipeline registers.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds three 32-bit output counters: stall_lu_cnt, stall_fetch_cnt, stall_mem_cnt.
  - Each increments once per cycle in which its condition is the winning priority.
  - Counters wrap at 2^32 and clear on startin.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: startin=1 for 2 cycles -> all enables=0, IF_IDFlush=1, state_o=0, fetch_err=0. Release -> all enables=1 with imem_ready=1.
- Load-use: EX_memread=1, EX_rt=5, ID_rs=5 for one cycle -> PCWrite=0, IF_IDWrite=0, ID_EXBubble=1 for exactly 1 cycle. Same stimulus with EX_rt=0 -> no stall.
- Branch vs load-use: branch_taken=1 and load_use both true -> IF_IDFlush=1, PCWrite=1, ID_EXBubble=0.
- Memory stall: mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all enables=0 for 3 cycles, state_o=1; the 4th cycle has enables=1, state_o returns 0.
- Fetch timeout: TIMEOUT=4, imem_ready=0 for 6 cycles -> state_o=2, fetch_err=1 from the cycle the counter hits 4. imem_ready=1 -> RUN, fetch_err stays 1 until startin.
- Mem stall during FETCH_WAIT: 2 fetch-wait cycles, then mem_req=1/dmem_ready=0 -> state_o=1 with the counter held at 2. dmem_ready=1 with imem_ready=0 -> FETCH_WAIT, counter continues to 3.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID/ID-EX/EX-MEM enables, flush and bubble
// from load-use, branch and memory-handshake hazards. Optional HAZARD_PERF_CNT_EN adds stall counters.
module hazard_stall_ctrl #(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              startin,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              ID_uses_rt,
  input  logic              EX_memread,
  input  logic [REG_AW-1:0] EX_rt,
  input  logic              branch_taken,
  input  logic              imem_ready,
  input  logic              mem_req,
  input  logic              dmem_ready,
  output logic              PCWrite,
  output logic              IF_IDWrite,
  output logic              IF_IDFlush,
  output logic              ID_EXWrite,
  output logic              ID_EXBubble,
  output logic              EX_MEMWrite,
  output logic              fetch_err,
  output logic [1:0]        state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_lu_cnt,
  output logic [31:0]       stall_fetch_cnt,
  output logic [31:0]       stall_mem_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_FETCH_WAIT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    WIN_MEM    = 3'd0,
    WIN_BRANCH = 3'd1,
    WIN_LU     = 3'd2,
    WIN_FETCH  = 3'd3,
    WIN_NONE   = 3'd4
  } win_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_fetch_err;
  win_t             w_win;
  logic             w_load_use;
  logic             w_mem_stall;
  logic             w_fetch_stall;
  logic             w_hold;

  assign w_load_use    = EX_memread && (EX_rt != '0) &&
                         ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
  assign w_mem_stall   = mem_req && !dmem_ready;
  assign w_fetch_stall = !imem_ready;
  // Once waiting on data memory, only dmem_ready releases the pipeline.
  assign w_hold        = (r_state == ST_MEM_WAIT) ? !dmem_ready : w_mem_stall;

  // Pick the winning hazard for this cycle.
  always_comb begin
    w_win = WIN_NONE;
    if (w_hold) begin
      w_win = WIN_MEM;
    end else if (branch_taken) begin
      w_win = WIN_BRANCH;
    end else if (w_load_use) begin
      w_win = WIN_LU;
    end else if (w_fetch_stall) begin
      w_win = WIN_FETCH;
    end else begin
      w_win = WIN_NONE;
    end
  end

  // Pipeline controls, next state and wait-counter update from the winner.
  always_comb begin
    PCWrite     = 1'b0;
    IF_IDWrite  = 1'b0;
    IF_IDFlush  = 1'b0;
    ID_EXWrite  = 1'b0;
    ID_EXBubble = 1'b0;
    EX_MEMWrite = 1'b0;
    w_state_nxt = ST_RUN;
    w_cnt_nxt   = '0;
    case (w_win)
      WIN_MEM: begin
        w_state_nxt = ST_MEM_WAIT;
        w_cnt_nxt   = r_cnt;
      end
      WIN_BRANCH: begin
        PCWrite     = 1'b1;
        IF_IDWrite  = 1'b1;
        IF_IDFlush  = 1'b1;
        ID_EXWrite  = 1'b1;
        EX_MEMWrite = 1'b1;
      end
      WIN_LU: begin
        ID_EXWrite  = 1'b1;
        ID_EXBubble = 1'b1;
        EX_MEMWrite = 1'b1;
      end
      WIN_FETCH: begin
        ID_EXWrite  = 1'b1;
        ID_EXBubble = 1'b1;
        EX_MEMWrite = 1'b1;
        w_state_nxt = ST_FETCH_WAIT;
        w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      default: begin
        PCWrite     = 1'b1;
        IF_IDWrite  = 1'b1;
        ID_EXWrite  = 1'b1;
        EX_MEMWrite = 1'b1;
      end
    endcase
    if (startin) begin
      PCWrite     = 1'b0;
      IF_IDWrite  = 1'b0;
      IF_IDFlush  = 1'b1;
      ID_EXWrite  = 1'b0;
      ID_EXBubble = 1'b1;
      EX_MEMWrite = 1'b0;
    end else begin
      IF_IDFlush  = IF_IDFlush;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (startin) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cnt_nxt >= TIMEOUT_C) begin
        r_fetch_err <= 1'b1;
      end else begin
        r_fetch_err <= r_fetch_err;
      end
    end
  end

  assign fetch_err = r_fetch_err;
  assign state_o   = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_lu_cnt;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_mem_cnt;

  // Per-cause stall counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (startin) begin
      r_lu_cnt    <= 32'd0;
      r_fetch_cnt <= 32'd0;
      r_mem_cnt   <= 32'd0;
    end else begin
      if (w_win == WIN_LU)    r_lu_cnt    <= r_lu_cnt + 32'd1;
      if (w_win == WIN_FETCH) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_win == WIN_MEM)   r_mem_cnt   <= r_mem_cnt + 32'd1;
    end
  end

  assign stall_lu_cnt    = r_lu_cnt;
  assign stall_fetch_cnt = r_fetch_cnt;
  assign stall_mem_cnt   = r_mem_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed table-driven bench for hazard_stall_ctrl (TIMEOUT=4) plus multi-cycle sequences.
module tb_hazard_stall_ctrl;

  localparam logic [5:0] O_RUN    = 6'b110101;  // {PC,IFID,Flush,IDEX,Bubble,EXMEM}
  localparam logic [5:0] O_STALL  = 6'b000111;
  localparam logic [5:0] O_BRANCH = 6'b111101;
  localparam logic [5:0] O_HOLD   = 6'b000000;
  localparam logic [5:0] O_RESET  = 6'b001010;

  logic       clk;
  logic       startin;
  logic [4:0] ID_rs, ID_rt, EX_rt;
  logic       ID_uses_rt, EX_memread, branch_taken, imem_ready, mem_req, dmem_ready;
  logic       PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble, EX_MEMWrite;
  logic       fetch_err;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_lu_cnt, stall_fetch_cnt, stall_mem_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  hazard_stall_ctrl #(.REG_AW(5), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .startin(startin),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_memread(EX_memread), .EX_rt(EX_rt), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .IF_IDFlush(IF_IDFlush),
    .ID_EXWrite(ID_EXWrite), .ID_EXBubble(ID_EXBubble), .EX_MEMWrite(EX_MEMWrite),
    .fetch_err(fetch_err), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_lu_cnt(stall_lu_cnt), .stall_fetch_cnt(stall_fetch_cnt),
    .stall_mem_cnt(stall_mem_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] ex_rt;
    logic       br;
    logic       imem;
    logic       mreq;
    logic       dmem;
    logic [5:0] outs;
    logic [1:0] nst;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [5:0] outs();
    return {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble, EX_MEMWrite};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ID_rs = v.rs; ID_rt = v.rt; ID_uses_rt = v.uses_rt;
    EX_memread = v.memread; EX_rt = v.ex_rt; branch_taken = v.br;
    imem_ready = v.imem; mem_req = v.mreq; dmem_ready = v.dmem;
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0; EX_memread = 1'b0; EX_rt = 5'd0;
    branch_taken = 1'b0; imem_ready = 1'b1; mem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    startin = 1'b1;
    cyc();
    startin = 1'b0;
  endtask

  initial begin
    //           rs     rt     use   mrd   ex_rt  br    imem  mreq  dmem  outs      next
    vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, O_RUN,    2'd0};
    vecs[1]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, O_STALL,  2'd0};
    vecs[2]  = '{5'd5,  5'd0,  1'b0, 1'b0, 5'd5,  1'b0, 1'b1, 1'b0, 1'b0, O_RUN,    2'd0};
    vecs[3]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, O_RUN,    2'd0};
    vecs[4]  = '{5'd3,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b1, 1'b0, 1'b0, O_STALL,  2'd0};
    vecs[5]  = '{5'd3,  5'd7,  1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b0, 1'b0, O_RUN,    2'd0};
    vecs[6]  = '{5'd9,  5'd2,  1'b1, 1'b1, 5'd4,  1'b0, 1'b1, 1'b0, 1'b0, O_RUN,    2'd0};
    vecs[7]  = '{5'd5,  5'd0,  1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, O_BRANCH, 2'd0};
    vecs[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_BRANCH, 2'd0};
    vecs[9]  = '{5'd1,  5'd2,  1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, O_BRANCH, 2'd0};
    vecs[10] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, O_RUN,    2'd0};
    vecs[11] = '{5'd8,  5'd0,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b1, 1'b1, O_STALL,  2'd0};

    // Reset held two cycles, with a branch pending to show it is masked.
    idle();
    branch_taken = 1'b1;
    startin = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("reset_outs%0d", k), 32'(outs()), 32'(O_RESET));
      chk($sformatf("reset_state%0d", k), 32'(state_o), 32'd0);
      chk($sformatf("reset_err%0d", k), 32'(fetch_err), 32'd0);
      cyc();
    end
    startin = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    chk("release_outs", 32'(outs()), 32'(O_RUN));
    cyc();

    // Single-cycle RUN vectors.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].outs));
      cyc();
      chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].nst));
    end

    // Memory stall: 3 hold cycles (branch pending in the first), then release.
    idle();
    mem_req = 1'b1;
    dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      branch_taken = (k == 0);
      @(negedge clk);
      chk($sformatf("mstall%0d_outs", k), 32'(outs()), 32'(O_HOLD));
      cyc();
      chk($sformatf("mstall%0d_state", k), 32'(state_o), 32'd1);
    end
    branch_taken = 1'b0;
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("mrel_outs", 32'(outs()), 32'(O_RUN));
    cyc();
    chk("mrel_state", 32'(state_o), 32'd0);

    // MEM_WAIT released into a load-use stall.
    dmem_ready = 1'b0;
    cyc();
    dmem_ready = 1'b1;
    EX_memread = 1'b1; EX_rt = 5'd6; ID_rs = 5'd6;
    @(negedge clk);
    chk("mrel_lu_outs", 32'(outs()), 32'(O_STALL));
    cyc();
    chk("mrel_lu_state", 32'(state_o), 32'd0);

    // Fetch timeout after 4 wait cycles, sticky until reset.
    idle();
    imem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("fw%0d_outs", k), 32'(outs()), 32'(O_STALL));
      cyc();
      chk($sformatf("fw%0d_state", k), 32'(state_o), 32'd2);
      chk($sformatf("fw%0d_err", k), 32'(fetch_err), (k >= 4) ? 32'd1 : 32'd0);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    chk("fw_rel_outs", 32'(outs()), 32'(O_RUN));
    cyc();
    chk("fw_rel_state", 32'(state_o), 32'd0);
    chk("fw_rel_err", 32'(fetch_err), 32'd1);
    cyc();
    chk("fw_sticky_err", 32'(fetch_err), 32'd1);
    do_reset();
    chk("fw_reset_err", 32'(fetch_err), 32'd0);

    // Counter restarts from zero after imem_ready: 3 waits must not time out.
    imem_ready = 1'b0;
    cyc(); cyc(); cyc();
    chk("fw_restart_err", 32'(fetch_err), 32'd0);
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    cyc(); cyc(); cyc();
    chk("fw_cleared_err", 32'(fetch_err), 32'd0);
    imem_ready = 1'b1;
    cyc();

    // Mem stall inside FETCH_WAIT holds the counter at 2.
    do_reset();
    imem_ready = 1'b0;
    cyc(); cyc();
    chk("fm_pre_state", 32'(state_o), 32'd2);
    mem_req = 1'b1;
    dmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("fm_hold%0d_outs", k), 32'(outs()), 32'(O_HOLD));
      cyc();
      chk($sformatf("fm_hold%0d_state", k), 32'(state_o), 32'd1);
      chk($sformatf("fm_hold%0d_err", k), 32'(fetch_err), 32'd0);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("fm_rel_outs", 32'(outs()), 32'(O_STALL));
    cyc();
    chk("fm_rel_state", 32'(state_o), 32'd2);
    chk("fm_cnt3_err", 32'(fetch_err), 32'd0);
    mem_req = 1'b0;
    cyc();
    chk("fm_cnt4_err", 32'(fetch_err), 32'd1);
    chk("fm_cnt4_state", 32'(state_o), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
